// File: rtl/collision_pkg.sv
// Shared state encoding and default geometry for the collision engine.
package collision_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BALL,
        PAIR,
        FINISH
    } state_t;

    localparam int NUM_PINS_DEF      = 10;
    localparam int X_W_DEF           = 11;
    localparam int Y_W_DEF           = 10;
    localparam int V_W_DEF           = 16;
    localparam int BALL_RADIUS_DEF   = 8;
    localparam int PIN_RADIUS_DEF    = 5;
    localparam int SCREEN_WIDTH_DEF  = 1024;
    localparam int SCREEN_HEIGHT_DEF = 768;

endpackage

// File: rtl/dist_sq_cmp.sv
// Combinational proximity test: o_hit when dx*dx + dy*dy <= i_thr (assumes Y_W <= X_W).
module dist_sq_cmp #(
    parameter int X_W = 11,
    parameter int Y_W = 10
) (
    input  logic [X_W-1:0]   i_a_x,
    input  logic [Y_W-1:0]   i_a_y,
    input  logic [X_W-1:0]   i_b_x,
    input  logic [Y_W-1:0]   i_b_y,
    input  logic [2*X_W+1:0] i_thr,
    output logic             o_hit
);

    localparam int SQ_W = 2 * (X_W + 1);

    logic signed [X_W:0]    w_dx;
    logic signed [Y_W:0]    w_dy;
    logic signed [SQ_W-1:0] w_dx_ext;
    logic signed [SQ_W-1:0] w_dy_ext;
    logic signed [SQ_W-1:0] w_dx_sq;
    logic signed [SQ_W-1:0] w_dy_sq;
    logic        [SQ_W-1:0] w_dist_sq;

    // Differences carry one extra bit so the full coordinate range never wraps.
    assign w_dx      = $signed({1'b0, i_a_x}) - $signed({1'b0, i_b_x});
    assign w_dy      = $signed({1'b0, i_a_y}) - $signed({1'b0, i_b_y});
    assign w_dx_ext  = SQ_W'(w_dx);
    assign w_dy_ext  = SQ_W'(w_dy);
    assign w_dx_sq   = w_dx_ext * w_dx_ext;
    assign w_dy_sq   = w_dy_ext * w_dy_ext;
    assign w_dist_sq = $unsigned(w_dx_sq) + $unsigned(w_dy_sq);
    assign o_hit     = (w_dist_sq <= i_thr);

endmodule

// File: rtl/collision_engine.sv
// Sequential ball/pin and pin/pin collision resolver sharing one distance comparator.
// Optional hit counter output coll_count_out when COLLISION_STATS_EN is defined.
module collision_engine
    import collision_pkg::*;
#(
    parameter int NUM_PINS      = NUM_PINS_DEF,
    parameter int X_W           = X_W_DEF,
    parameter int Y_W           = Y_W_DEF,
    parameter int V_W           = V_W_DEF,
    parameter int BALL_RADIUS   = BALL_RADIUS_DEF,
    parameter int PIN_RADIUS    = PIN_RADIUS_DEF,
    parameter int SCREEN_WIDTH  = SCREEN_WIDTH_DEF,
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic                          valid_in,
    output logic                          ready_out,
    input  logic [X_W-1:0]                ball_x,
    input  logic [Y_W-1:0]                ball_y,
    input  logic [V_W-1:0]                ball_vx_in,
    input  logic [V_W-1:0]                ball_vy_in,
    input  logic [NUM_PINS-1:0][X_W-1:0]  pins_x,
    input  logic [NUM_PINS-1:0][Y_W-1:0]  pins_y,
    input  logic [NUM_PINS-1:0][V_W-1:0]  pins_vx_in,
    input  logic [NUM_PINS-1:0][V_W-1:0]  pins_vy_in,
    output logic [NUM_PINS-1:0][V_W-1:0]  pins_vx_out,
    output logic [NUM_PINS-1:0][V_W-1:0]  pins_vy_out,
    output logic [NUM_PINS-1:0]           pins_hit,
`ifdef COLLISION_STATS_EN
    output logic [15:0]                   coll_count_out,
`endif
    output logic                          done
);

    localparam int IDX_W = (NUM_PINS > 2) ? $clog2(NUM_PINS) : 1;
    localparam int SQ_W  = 2 * (X_W + 1);
    localparam logic [SQ_W-1:0]  BALL_THR = SQ_W'((BALL_RADIUS + PIN_RADIUS) * (BALL_RADIUS + PIN_RADIUS));
    localparam logic [SQ_W-1:0]  PAIR_THR = SQ_W'((2 * PIN_RADIUS) * (2 * PIN_RADIUS));
    localparam logic [IDX_W-1:0] LAST_J   = IDX_W'(NUM_PINS - 1);
    localparam logic [IDX_W-1:0] LAST_I   = IDX_W'(NUM_PINS - 2);

    state_t                        r_state;
    state_t                        w_state_nxt;
    logic [IDX_W-1:0]              r_i;
    logic [IDX_W-1:0]              r_j;
    logic [X_W-1:0]                r_ball_x;
    logic [Y_W-1:0]                r_ball_y;
    logic [V_W-1:0]                r_ball_vx;
    logic [V_W-1:0]                r_ball_vy;
    logic [NUM_PINS-1:0][X_W-1:0]  r_pin_x;
    logic [NUM_PINS-1:0][Y_W-1:0]  r_pin_y;
    logic [NUM_PINS-1:0][V_W-1:0]  r_vx;
    logic [NUM_PINS-1:0][V_W-1:0]  r_vy;
    logic [NUM_PINS-1:0]           r_work_hit;
    logic [NUM_PINS-1:0]           r_hit;
    logic [NUM_PINS-1:0][V_W-1:0]  r_vx_out;
    logic [NUM_PINS-1:0][V_W-1:0]  r_vy_out;
    logic                          r_done;

    logic                          w_accept;
    logic [NUM_PINS-1:0]           w_on_screen;
    logic [X_W-1:0]                w_a_x;
    logic [Y_W-1:0]                w_a_y;
    logic [X_W-1:0]                w_b_x;
    logic [Y_W-1:0]                w_b_y;
    logic [SQ_W-1:0]               w_thr;
    logic                          w_near;
    logic                          w_hit;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) r_state <= IDLE;
        else           r_state <= w_state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        ready_out   = 1'b0;
        case (r_state)
            IDLE: begin
                ready_out = 1'b1;
                if (valid_in) w_state_nxt = BALL;
            end
            BALL:    if (r_i == LAST_J) w_state_nxt = PAIR;
            PAIR:    if ((r_i == LAST_I) && (r_j == LAST_J)) w_state_nxt = FINISH;
            FINISH:  w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign w_accept = ready_out && valid_in;

    always_comb begin
        w_on_screen = '0;
        for (int k = 0; k < NUM_PINS; k++) begin
            w_on_screen[k] = (int'(r_pin_x[k]) < SCREEN_WIDTH) && (int'(r_pin_y[k]) < SCREEN_HEIGHT);
        end
    end

    // BALL compares the ball against pin i; PAIR compares pin i against pin j.
    always_comb begin
        w_a_x = r_pin_x[r_i];
        w_a_y = r_pin_y[r_i];
        w_b_x = r_pin_x[r_j];
        w_b_y = r_pin_y[r_j];
        w_thr = PAIR_THR;
        if (r_state == BALL) begin
            w_a_x = r_ball_x;
            w_a_y = r_ball_y;
            w_b_x = r_pin_x[r_i];
            w_b_y = r_pin_y[r_i];
            w_thr = BALL_THR;
        end
    end

    dist_sq_cmp #(.X_W(X_W), .Y_W(Y_W)) u_dist_sq_cmp (
        .i_a_x (w_a_x),
        .i_a_y (w_a_y),
        .i_b_x (w_b_x),
        .i_b_y (w_b_y),
        .i_thr (w_thr),
        .o_hit (w_near)
    );

    assign w_hit = w_near && w_on_screen[r_i] &&
                   ((r_state == BALL) || ((r_state == PAIR) && w_on_screen[r_j]));

    // NOTE: working registers are few enough to sit in flops, so they are reset along with the outputs.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_i        <= '0;
            r_j        <= '0;
            r_ball_x   <= '0;
            r_ball_y   <= '0;
            r_ball_vx  <= '0;
            r_ball_vy  <= '0;
            r_pin_x    <= '0;
            r_pin_y    <= '0;
            r_vx       <= '0;
            r_vy       <= '0;
            r_work_hit <= '0;
            r_hit      <= '0;
            r_vx_out   <= '0;
            r_vy_out   <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_i        <= '0;
                        r_j        <= '0;
                        r_ball_x   <= ball_x;
                        r_ball_y   <= ball_y;
                        r_ball_vx  <= ball_vx_in;
                        r_ball_vy  <= ball_vy_in;
                        r_pin_x    <= pins_x;
                        r_pin_y    <= pins_y;
                        r_vx       <= pins_vx_in;
                        r_vy       <= pins_vy_in;
                        r_work_hit <= '0;
                    end
                end
                BALL: begin
                    if (w_hit) begin
                        r_vx[r_i]       <= r_ball_vx;
                        r_vy[r_i]       <= r_ball_vy;
                        r_work_hit[r_i] <= 1'b1;
                    end
                    if (r_i == LAST_J) begin
                        r_i <= '0;
                        r_j <= IDX_W'(1);
                    end else begin
                        r_i <= r_i + IDX_W'(1);
                    end
                end
                PAIR: begin
                    // NOTE: non-blocking assignment makes both sides read the pre-swap values.
                    if (w_hit) begin
                        r_vx[r_i]       <= r_vx[r_j];
                        r_vx[r_j]       <= r_vx[r_i];
                        r_vy[r_i]       <= r_vy[r_j];
                        r_vy[r_j]       <= r_vy[r_i];
                        r_work_hit[r_i] <= 1'b1;
                        r_work_hit[r_j] <= 1'b1;
                    end
                    if (r_j == LAST_J) begin
                        r_i <= r_i + IDX_W'(1);
                        r_j <= r_i + IDX_W'(2);
                    end else begin
                        r_j <= r_j + IDX_W'(1);
                    end
                end
                FINISH: begin
                    r_vx_out <= r_vx;
                    r_vy_out <= r_vy;
                    r_hit    <= r_hit | r_work_hit;
                    r_done   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pins_vx_out = r_vx_out;
    assign pins_vy_out = r_vy_out;
    assign pins_hit    = r_hit;
    assign done        = r_done;

`ifdef COLLISION_STATS_EN
    logic [15:0] r_coll_count;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_coll_count <= '0;
        end else if (w_hit && (r_coll_count != 16'hFFFF)) begin
            r_coll_count <= r_coll_count + 16'd1;
        end
    end

    assign coll_count_out = r_coll_count;
`endif

endmodule

// File: doc/collision_engine.md
COLLISION_ENGINE -- requirements
Module: collision_engine

Interface
REQ-001 SHALL have parameter NUM_PINS, default 10, the number of pin channels (2..16).
REQ-002 SHALL have parameters X_W=11, Y_W=10, V_W=16, giving the position and velocity widths.
REQ-003 SHALL have parameters BALL_RADIUS=8, PIN_RADIUS=5, SCREEN_WIDTH=1024, SCREEN_HEIGHT=768, all in pixels.
REQ-004 clk_in  input  1  sole clock; all logic is on the rising edge.
REQ-005 rst_n_in  input  1  asynchronous, active-low reset.
REQ-006 valid_in  input  1  start request; accepted only while ready_out=1.
REQ-007 ready_out  output  1  engine idle and able to accept a start.
REQ-008 ball_x / ball_y  input  X_W / Y_W  ball position.
REQ-009 ball_vx_in / ball_vy_in  input  V_W each  ball velocity, two's complement.
REQ-010 pins_x / pins_y  input  NUM_PINS x X_W / Y_W  pin positions.
REQ-011 pins_vx_in / pins_vy_in  input  NUM_PINS x V_W  pin velocities.
REQ-012 pins_vx_out / pins_vy_out  output  NUM_PINS x V_W  resolved velocities.
REQ-013 pins_hit  output  NUM_PINS  sticky per-pin hit flags.
REQ-014 done  output  1  one-cycle pulse when a pass completes.

Function
REQ-015 On the cycle where valid_in=1 and ready_out=1, the engine SHALL latch all inputs into working registers, seed the working velocities with pins_v*_in, and enter BALL.
REQ-016 States SHALL be IDLE->BALL->PAIR->FINISH->IDLE; ready_out=1 only in IDLE.
REQ-017 BALL SHALL test one pin per cycle, i=0..NUM_PINS-1 in order.
REQ-018 PAIR SHALL test one pair per cycle in lexicographic order (i,j), i<j, for NUM_PINS*(NUM_PINS-1)/2 cycles.
REQ-019 Latency from accept to the done pulse SHALL be exactly NUM_PINS + NUM_PINS*(NUM_PINS-1)/2 + 1 cycles; for NUM_PINS=10 this is 56.
REQ-020 Squared distance SHALL be computed as dx*dx+dy*dy, using signed (width+1) differences and an unsigned result of 2*(X_W+1) bits, with no truncation.
REQ-021 A ball hit SHALL occur when dist_sq <= (BALL_RADIUS+PIN_RADIUS)^2, inclusive.
REQ-022 A pair hit SHALL occur when dist_sq <= (2*PIN_RADIUS)^2, inclusive.
REQ-023 A ball hit SHALL set the working v[i] to the ball velocity (equal-mass elastic) and set hit[i].
REQ-024 A pair hit SHALL swap the working v[i] and v[j] and set hit[i] and hit[j].
REQ-025 Pair tests SHALL use the current working velocities, so velocity propagates through a chain of pins within one pass.
REQ-026 A pin with x>=SCREEN_WIDTH or y>=SCREEN_HEIGHT SHALL be excluded from every test involving it.
REQ-027 In FINISH, pins_v*_out SHALL be loaded from the working registers and done SHALL be pulsed.
REQ-028 Outputs SHALL hold between passes.
REQ-029 pins_hit SHALL be OR-accumulated across passes and SHALL be cleared only by reset.
REQ-030 valid_in while busy SHALL be ignored; it is not queued.
REQ-031 Changes on the inputs mid-pass SHALL have no effect, because the inputs are latched at accept.

Reset
REQ-032 While rst_n_in=0, the engine SHALL be in state IDLE with ready_out=1, done=0, pins_hit=0, pins_v*_out=0, and all counters and working registers at 0.
REQ-033 Reset asserted mid-pass SHALL abort the pass immediately, with no done pulse and no partial output update.
REQ-034 The first accept SHALL be possible on the first clock edge after deassertion.

Configuration
REQ-035 When macro COLLISION_STATS_EN is defined, the engine SHALL add output coll_count_out (16 bits), which counts ball hits plus pair hits and saturates at 0xFFFF.
REQ-036 coll_count_out SHALL be cleared by reset only.
REQ-037 When COLLISION_STATS_EN is undefined, the port and counter SHALL be absent; all other behaviour is identical.

Structure
REQ-038 Package collision_pkg SHALL hold the state enum (IDLE, BALL, PAIR, FINISH) and the width and radius default constants.
REQ-039 Sub-module dist_sq_cmp SHALL be combinational and SHALL take two points and a threshold, returning a hit flag.
REQ-040 dist_sq_cmp SHALL be instantiated once and shared by BALL and PAIR.

Verification
REQ-041 Ball at (100,100), pin0 at (110,105), all others off-screen at x=2000, ball_v=(5,-3) -> pin0 v=(5,-3), pins_hit=0x001, done at cycle 56.
REQ-042 Ball at (100,100), pin0 at (113,100) (dist_sq=169) -> hit; pin0 at (114,100) -> no hit, and its velocity is unchanged.
REQ-043 Chain test: ball hits pin0; pin1 is at distance 10 from pin0 with v=0 -> pin0 v=0, pin1 v=ball_v, pins_hit=0x003.
REQ-044 Pin2 at (1024,50) overlapping pin3 -> no swap and no hit for pin2.
REQ-045 Pulse valid_in at cycle 20 of a pass, then drop rst_n_in at cycle 30 -> no done, all outputs 0, ready_out=1.
REQ-046 With COLLISION_STATS_EN defined, running REQ-043 twice -> coll_count_out=4.
